// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and rise-to-rise period, flags stuck inputs by timeout; optional glitch filter under PWM_CAPTURE_FILTER_EN.
// Latency: valid SYNC_STAGES+1 cycles after the closing rising edge of pwm_in (+FILTER_LEN with the filter).
// Backpressure: none; valid is a one-cycle strobe and the results hold until the next strobe.
module pwm_capture #(
    parameter int CNT_W       = 11,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] pulse_width,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] MAX = '1;

    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_param
        $error("pwm_capture: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_raw;
    logic                   pwm_s;
    logic                   pwm_d;
    logic                   rise;
    logic                   fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign pwm_raw = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FCW      = $clog2(FILTER_LEN + 1);
    localparam int WARM_LEN = SYNC_STAGES + FILTER_LEN;

    logic [FCW-1:0] flt_cnt;
    logic           flt_lvl;

    always_ff @(posedge clk) begin
        if (reset) begin
            flt_lvl <= 1'b0;
            flt_cnt <= '0;
        end else if (pwm_raw != flt_lvl) begin
            if (flt_cnt == FCW'(FILTER_LEN - 1)) begin
                flt_lvl <= pwm_raw;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end else begin
            flt_cnt <= '0;
        end
    end

    assign pwm_s = flt_lvl;
`else
    localparam int WARM_LEN = SYNC_STAGES;

    assign pwm_s = pwm_raw;
`endif

    // The input path restarts from 0 after reset; IDLE must not judge the line
    // level until a real sample has propagated, or a held-high input would look
    // low and then produce a false first edge.
    logic [WARM_LEN-1:0] warm_q;
    logic                warm_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            warm_q <= '0;
            pwm_d  <= 1'b0;
        end else begin
            warm_q <= {warm_q[WARM_LEN-2:0], 1'b1};
            pwm_d  <= pwm_s;
        end
    end

    assign warm_ok = warm_q[WARM_LEN-1];
    assign rise    = pwm_s & ~pwm_d;
    assign fall    = ~pwm_s & pwm_d;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hi_cnt, hi_nxt, hi_inc;
    logic [CNT_W-1:0] per_cnt, per_nxt, per_inc;
    logic             timeout;
    logic             rpt;
    logic [CNT_W-1:0] rpt_pw;
    logic [CNT_W-1:0] rpt_per;
    logic             rpt_ovf;

    assign hi_inc  = (hi_cnt == MAX) ? MAX : hi_cnt + 1'b1;
    assign per_inc = (per_cnt == MAX) ? MAX : per_cnt + 1'b1;
    // A rise landing exactly on a full counter is a legal MAX-length period.
    assign timeout = (per_cnt == MAX) && !rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            hi_cnt  <= '0;
            per_cnt <= '0;
        end else begin
            state   <= state_nxt;
            hi_cnt  <= hi_nxt;
            per_cnt <= per_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hi_nxt    = hi_cnt;
        per_nxt   = per_inc;
        rpt       = 1'b0;
        rpt_pw    = hi_cnt;
        rpt_per   = per_cnt;
        rpt_ovf   = 1'b0;
        if (timeout) begin
            rpt       = 1'b1;
            rpt_pw    = pwm_s ? MAX : '0;
            rpt_per   = MAX;
            rpt_ovf   = 1'b1;
            hi_nxt    = '0;
            per_nxt   = '0;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!pwm_s && warm_ok) begin
                        state_nxt = ARM;
                    end
                end
                ARM: begin
                    if (rise) begin
                        hi_nxt    = CNT_W'(1);
                        per_nxt   = CNT_W'(1);
                        state_nxt = HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_nxt = LOW;
                    end else begin
                        hi_nxt = hi_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        rpt       = 1'b1;
                        rpt_pw    = hi_cnt;
                        rpt_per   = per_cnt;
                        rpt_ovf   = 1'b0;
                        hi_nxt    = CNT_W'(1);
                        per_nxt   = CNT_W'(1);
                        state_nxt = HIGH;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_width <= '0;
            period      <= '0;
            valid       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            valid <= rpt;
            if (rpt) begin
                pulse_width <= rpt_pw;
                period      <= rpt_per;
                overflow    <= rpt_ovf;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: clean periods, stuck-low/high timeouts, mid-cycle reset, MAX period, glitches.
module tb_pwm_capture;

    localparam int CNT_W = 11;
    localparam int MAXV  = 2047;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             pwm_in;
    logic [CNT_W-1:0] pulse_width;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             overflow;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int ev_pw[$];
    int ev_per[$];
    int ev_ovf[$];
    int ev_cyc[$];

    pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .pulse_width (pulse_width),
        .period      (period),
        .valid       (valid),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            ev_pw.push_back(int'(pulse_width));
            ev_per.push_back(int'(period));
            ev_ovf.push_back(int'(overflow));
            ev_cyc.push_back(cyc);
        end
    end

    task automatic drive(input logic lvl, input int n);
        pwm_in = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_ev;
        ev_pw.delete();
        ev_per.delete();
        ev_ovf.delete();
        ev_cyc.delete();
    endtask

    task automatic do_reset(input logic lvl);
        pwm_in = lvl;
        reset  = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        clear_ev();
    endtask

    task automatic test_reset;
        pwm_in = 1'b0;
        reset  = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_cmp++;
        if (pulse_width !== '0) begin n_err++; $display("FAIL reset_pw: got %0d want 0", pulse_width); end
        n_cmp++;
        if (period !== '0) begin n_err++; $display("FAIL reset_per: got %0d want 0", period); end
        n_cmp++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_periodic;
        int r2;
        r2 = 0;
        do_reset(1'b0);
        drive(1'b0, 10);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) r2 = cyc;
            drive(1'b1, 200);
            drive(1'b0, 824);
        end
        drive(1'b1, 8);
        n_cmp++;
        if (ev_pw.size() != 5) begin n_err++; $display("FAIL periodic_count: got %0d want 5", ev_pw.size()); end
        for (int i = 0; i < ev_pw.size(); i++) begin
            n_cmp++;
            if (ev_pw[i] !== 200 || ev_per[i] !== 1024 || ev_ovf[i] !== 0) begin
                n_err++;
                $display("FAIL periodic_ev%0d: got %0d/%0d ovf=%0d want 200/1024 ovf=0", i, ev_pw[i], ev_per[i], ev_ovf[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (ev_cyc[i] - ev_cyc[i-1] !== 1024) begin
                    n_err++;
                    $display("FAIL periodic_spacing%0d: got %0d want 1024", i, ev_cyc[i] - ev_cyc[i-1]);
                end
            end
        end
        if (ev_cyc.size() > 0) begin
            n_cmp++;
            if (ev_cyc[0] !== r2 + LAT) begin
                n_err++;
                $display("FAIL periodic_latency: got %0d want %0d", ev_cyc[0] - r2, LAT);
            end
        end
        n_cmp++;
        if (pulse_width !== 11'd200 || period !== 11'd1024 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL periodic_hold: got %0d/%0d v=%b want 200/1024 v=0", pulse_width, period, valid);
        end
    endtask

    task automatic test_stuck_low;
        do_reset(1'b0);
        drive(1'b0, 10);
        drive(1'b1, 200);
        drive(1'b0, 824);
        drive(1'b1, 200);
        drive(1'b0, 4200);
        n_cmp++;
        if (ev_pw.size() != 3) begin n_err++; $display("FAIL stuck_low_count: got %0d want 3", ev_pw.size()); end
        if (ev_pw.size() == 3) begin
            n_cmp++;
            if (ev_pw[0] !== 200 || ev_per[0] !== 1024 || ev_ovf[0] !== 0) begin
                n_err++; $display("FAIL stuck_low_first: got %0d/%0d ovf=%0d want 200/1024 ovf=0", ev_pw[0], ev_per[0], ev_ovf[0]);
            end
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (ev_pw[i] !== 0 || ev_per[i] !== MAXV || ev_ovf[i] !== 1) begin
                    n_err++; $display("FAIL stuck_low_to%0d: got %0d/%0d ovf=%0d want 0/2047 ovf=1", i, ev_pw[i], ev_per[i], ev_ovf[i]);
                end
            end
            n_cmp++;
            if (ev_cyc[1] - ev_cyc[0] !== 2047) begin
                n_err++; $display("FAIL stuck_low_first_to_gap: got %0d want 2047", ev_cyc[1] - ev_cyc[0]);
            end
            n_cmp++;
            if (ev_cyc[2] - ev_cyc[1] !== 2048) begin
                n_err++; $display("FAIL stuck_low_repeat_gap: got %0d want 2048", ev_cyc[2] - ev_cyc[1]);
            end
        end
        n_cmp++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL stuck_low_ovf: got %b want 1", overflow); end
    endtask

    task automatic test_stuck_high;
        do_reset(1'b1);
        drive(1'b1, 2100);
        n_cmp++;
        if (ev_pw.size() != 1) begin n_err++; $display("FAIL stuck_high_count: got %0d want 1", ev_pw.size()); end
        if (ev_pw.size() >= 1) begin
            n_cmp++;
            if (ev_pw[0] !== MAXV || ev_per[0] !== MAXV || ev_ovf[0] !== 1) begin
                n_err++; $display("FAIL stuck_high_to: got %0d/%0d ovf=%0d want 2047/2047 ovf=1", ev_pw[0], ev_per[0], ev_ovf[0]);
            end
        end
        drive(1'b0, 400);
        drive(1'b1, 100);
        drive(1'b0, 400);
        n_cmp++;
        if (overflow !== 1'b1 || ev_pw.size() != 1) begin
            n_err++; $display("FAIL stuck_high_first_rise: got ovf=%b events=%0d want ovf=1 events=1", overflow, ev_pw.size());
        end
        drive(1'b1, 10);
        n_cmp++;
        if (ev_pw.size() != 2) begin n_err++; $display("FAIL stuck_high_recover_count: got %0d want 2", ev_pw.size()); end
        if (ev_pw.size() >= 2) begin
            n_cmp++;
            if (ev_pw[1] !== 100 || ev_per[1] !== 500 || ev_ovf[1] !== 0) begin
                n_err++; $display("FAIL stuck_high_recover: got %0d/%0d ovf=%0d want 100/500 ovf=0", ev_pw[1], ev_per[1], ev_ovf[1]);
            end
        end
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL stuck_high_ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid;
        do_reset(1'b0);
        drive(1'b0, 10);
        drive(1'b1, 300);
        drive(1'b0, 700);
        drive(1'b1, 150);
        reset = 1'b1;
        drive(1'b1, 2);
        reset = 1'b0;
        n_cmp++;
        if (pulse_width !== '0 || period !== '0 || ev_pw.size() != 1) begin
            n_err++; $display("FAIL reset_mid_clear: got %0d/%0d events=%0d want 0/0 events=1", pulse_width, period, ev_pw.size());
        end
        drive(1'b1, 148);
        drive(1'b0, 700);
        drive(1'b1, 300);
        drive(1'b0, 700);
        drive(1'b1, 10);
        n_cmp++;
        if (ev_pw.size() != 2) begin n_err++; $display("FAIL reset_mid_count: got %0d want 2", ev_pw.size()); end
        for (int i = 0; i < ev_pw.size(); i++) begin
            n_cmp++;
            if (ev_pw[i] !== 300 || ev_per[i] !== 1000 || ev_ovf[i] !== 0) begin
                n_err++; $display("FAIL reset_mid_ev%0d: got %0d/%0d ovf=%0d want 300/1000 ovf=0", i, ev_pw[i], ev_per[i], ev_ovf[i]);
            end
        end
    endtask

    task automatic test_period_max;
        do_reset(1'b0);
        drive(1'b0, 10);
        drive(1'b1, 100);
        drive(1'b0, 1947);
        drive(1'b1, 100);
        drive(1'b0, 1947);
        drive(1'b1, 10);
        n_cmp++;
        if (ev_pw.size() != 2) begin n_err++; $display("FAIL period_max_count: got %0d want 2", ev_pw.size()); end
        for (int i = 0; i < ev_pw.size(); i++) begin
            n_cmp++;
            if (ev_pw[i] !== 100 || ev_per[i] !== MAXV || ev_ovf[i] !== 0) begin
                n_err++; $display("FAIL period_max_ev%0d: got %0d/%0d ovf=%0d want 100/2047 ovf=0", i, ev_pw[i], ev_per[i], ev_ovf[i]);
            end
        end
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL period_max_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_glitch;
        int exp_pw[$];
        int exp_per[$];
        do_reset(1'b0);
        drive(1'b0, 10);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 80);
            drive(1'b0, 2);
            drive(1'b1, 118);
            drive(1'b0, 824);
        end
        drive(1'b1, 10);
`ifdef PWM_CAPTURE_FILTER_EN
        exp_pw  = '{200, 200, 200};
        exp_per = '{1024, 1024, 1024};
`else
        exp_pw  = '{80, 118, 80, 118, 80, 118};
        exp_per = '{82, 942, 82, 942, 82, 942};
`endif
        n_cmp++;
        if (ev_pw.size() != exp_pw.size()) begin
            n_err++; $display("FAIL glitch_count: got %0d want %0d", ev_pw.size(), exp_pw.size());
        end
        for (int i = 0; i < ev_pw.size() && i < exp_pw.size(); i++) begin
            n_cmp++;
            if (ev_pw[i] !== exp_pw[i] || ev_per[i] !== exp_per[i] || ev_ovf[i] !== 0) begin
                n_err++; $display("FAIL glitch_ev%0d: got %0d/%0d ovf=%0d want %0d/%0d ovf=0", i, ev_pw[i], ev_per[i], ev_ovf[i], exp_pw[i], exp_per[i]);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        pwm_in = 1'b0;
        test_reset();
        test_periodic();
        test_stuck_low();
        test_stuck_high();
        test_reset_mid();
        test_period_max();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
